// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst arbiter sharing one async-FIFO read port, returns id-tagged words
module fifo_rd_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNTW      = 3,
  parameter int STALL_TO  = 8
) (
  input  logic             i_rd_clk,
  input  logic             i_rd_rst_n,
  input  logic [NREQ-1:0]  i_req,
  input  logic             i_empty,
  input  logic [DSIZE-1:0] i_rd_data,
  output logic             o_rd_en,
  output logic [NREQ-1:0]  o_gnt,
  output logic             o_busy,
  output logic             o_valid,
  output logic [IDW-1:0]   o_id,
  output logic [DSIZE-1:0] o_data,
  output logic             o_last
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [NREQ-1:0] gnt_nx;
  logic [IDW-1:0] owner, owner_nx, rr_last, rr_nx, win, cand;
  logic [CNTW-1:0] beat_cnt, beat_nx, stall_cnt, stall_nx;
  logic found, req_own, last_beat, exit_burst;
  always_comb begin
    win = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(rr_last) + k) % NREQ);
      if (!found && i_req[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  assign req_own   = i_req[owner];
  assign o_rd_en   = (state == BURST) && req_own && !i_empty;
  assign last_beat = beat_cnt == CNTW'(BURST_LEN - 1);
  // a dropped request wins over an empty stall; otherwise pop end or stall timeout releases
  assign exit_burst = !req_own || (o_rd_en && last_beat) ||
                      (!o_rd_en && stall_cnt == CNTW'(STALL_TO - 1));
  assign o_busy = state == BURST;
  assign o_data = o_valid ? i_rd_data : '0;
  always_comb begin
    state_nx = state;
    gnt_nx   = o_gnt;
    owner_nx = owner;
    rr_nx    = rr_last;
    beat_nx  = beat_cnt;
    stall_nx = stall_cnt;
    if (state == IDLE) begin
      if (found && !i_empty) begin
        state_nx = BURST;
        gnt_nx   = NREQ'(1) << win;
        owner_nx = win;
        beat_nx  = '0;
        stall_nx = '0;
      end
    end else if (exit_burst) begin
      state_nx = IDLE;
      gnt_nx   = '0;
      rr_nx    = owner;
      beat_nx  = '0;
      stall_nx = '0;
    end else begin
      beat_nx  = o_rd_en ? beat_cnt + 1'b1 : beat_cnt;
      stall_nx = o_rd_en ? '0 : stall_cnt + 1'b1;
    end
  end
  always_ff @(posedge i_rd_clk or negedge i_rd_rst_n) begin
    if (!i_rd_rst_n) begin
      state     <= IDLE;
      o_gnt     <= '0;
      owner     <= '0;
      rr_last   <= IDW'(NREQ - 1);
      beat_cnt  <= '0;
      stall_cnt <= '0;
      o_valid   <= 1'b0;
      o_id      <= '0;
      o_last    <= 1'b0;
    end else begin
      state     <= state_nx;
      o_gnt     <= gnt_nx;
      owner     <= owner_nx;
      rr_last   <= rr_nx;
      beat_cnt  <= beat_nx;
      stall_cnt <= stall_nx;
      o_valid   <= o_rd_en;
      o_id      <= owner;
      o_last    <= o_rd_en && last_beat;
    end
  end
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: directed scoreboard bench with a behavioural FIFO feeding the arbiter
module tb_fifo_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic i_empty = 1'b1;
  logic [7:0] rd_data = '0;
  logic rd_en, busy, valid, last;
  logic [3:0] gnt;
  logic [1:0] id;
  logic [7:0] data;
  logic [7:0] mem[$];
  logic [10:0] exp_w[$];
  logic [3:0] exp_g[$];
  logic [3:0] prev_gnt = '0;
  int tests = 0;
  int failed = 0;
  fifo_rd_arbiter dut (
    .i_rd_clk(clk), .i_rd_rst_n(rst_n), .i_req(req), .i_empty(i_empty),
    .i_rd_data(rd_data), .o_rd_en(rd_en), .o_gnt(gnt), .o_busy(busy),
    .o_valid(valid), .o_id(id), .o_data(data), .o_last(last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rd_en && mem.size() != 0) rd_data <= mem.pop_front();
    i_empty <= mem.size() == 0;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (valid) begin
      if (exp_w.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_word: got id=%0d data=%0h last=%0b expected none", id, data, last);
      end else chk("word{id,data,last}", {id, data, last}, exp_w.pop_front());
    end
    if (gnt != 0 && gnt != prev_gnt) begin
      chk("grant_spacing_prev", prev_gnt, 0);
      if (exp_g.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_grant: got %b expected none", gnt);
      end else chk("grant", gnt, exp_g.pop_front());
    end
    prev_gnt <= gnt;
  end
  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) mem.push_back(base + 8'(i));
  endtask
  task automatic ew(input logic [1:0] i, input logic [7:0] d, input logic l);
    exp_w.push_back({i, d, l});
  endtask
  task automatic wait_gnt(input logic [3:0] e, input int budget, input string name);
    int n = 0;
    while (gnt !== e && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, gnt, e);
  endtask
  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_w.size() != 0 || exp_g.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, exp_w.size() + exp_g.size(), 0);
  endtask
  initial begin
    int nrd, ng;
    // 1: three words, lone requester 0, then stall timeout
    @(negedge clk);
    load(3, 8'h10);
    req = 4'b0001;
    exp_g.push_back(4'b0001);
    ew(0, 8'h10, 0); ew(0, 8'h11, 0); ew(0, 8'h12, 0);
    @(negedge clk);
    chk("t1_reset_outputs", {gnt, busy, valid, last, rd_en, id, data}, 0);
    @(negedge clk);
    chk("t1_reset_outputs2", {gnt, busy, valid, last, rd_en, id, data}, 0);
    rst_n = 1'b1;
    nrd = 0;
    ng = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (i == 0) chk("t1_gnt_cycle2", gnt, 4'b0001);
      nrd += int'(rd_en);
      ng += int'(gnt != 0);
    end
    chk("t1_pop_count", nrd, 3);
    chk("t1_gnt_cycles", ng, 11);
    req = '0;
    wait_drain(5, "t1_drain");
    // 2: all four requesting, 20 words
    rst_n = 1'b0;
    load(20, 8'h20);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g.push_back(4'b0001 << (g % 4));
      for (int j = 0; j < 4; j++) ew(2'(g % 4), 8'h20 + 8'(4 * g + j), j == 3);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(80, "t2_drain");
    chk("t2_fifo_empty", mem.size(), 0);
    req = '0;
    // 3: requester 2 alone with a 3-cycle empty gap after 2 pops
    @(negedge clk);
    rst_n = 1'b0;
    load(2, 8'h30);
    req = 4'b0100;
    exp_g.push_back(4'b0100);
    ew(2, 8'h30, 0); ew(2, 8'h31, 0); ew(2, 8'h32, 0); ew(2, 8'h33, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10 && !(i_empty && gnt == 4'b0100); n++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_gnt_rd_en", {gnt, rd_en}, {4'b0100, 1'b0});
      if (i < 2) @(negedge clk);
    end
    load(2, 8'h32);
    wait_drain(10, "t3_drain");
    chk("t3_release_after_last", gnt, 0);
    req = '0;
    // 4: requester 0 drops after 2 pops, requester 1 follows
    @(negedge clk);
    rst_n = 1'b0;
    load(6, 8'h40);
    req = 4'b0011;
    exp_g.push_back(4'b0001);
    exp_g.push_back(4'b0010);
    ew(0, 8'h40, 0); ew(0, 8'h41, 0);
    ew(1, 8'h42, 0); ew(1, 8'h43, 0); ew(1, 8'h44, 0); ew(1, 8'h45, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(4'b0001, 5, "t4_first_gnt");
    @(negedge clk);
    @(negedge clk);
    req = 4'b0010;
    #1;
    chk("t4_no_pop_on_drop", rd_en, 0);
    @(negedge clk);
    chk("t4_released", {gnt, valid, last}, 0);
    wait_drain(15, "t4_drain");
    req = '0;
    // 5: reset in the cycle after the 2nd pop
    @(negedge clk);
    rst_n = 1'b0;
    load(4, 8'h50);
    req = 4'b0001;
    exp_g.push_back(4'b0001);
    ew(0, 8'h50, 0); ew(0, 8'h51, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(4'b0001, 5, "t5_first_gnt");
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t5_pre_reset_active", {gnt, valid, rd_en}, {4'b0001, 1'b1, 1'b1});
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_reset_outs", {gnt, valid, rd_en}, 0);
    @(negedge clk);
    req = 4'b0011;
    exp_g.push_back(4'b0001);
    ew(0, 8'h52, 0); ew(0, 8'h53, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(10, "t5_drain");
    wait_gnt(4'b0000, 20, "t5_stall_release");
    req = '0;
    // 6: requester 3 waits on an empty FIFO
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_grant_while_empty", {gnt, rd_en}, 0);
    end
    load(1, 8'h60);
    exp_g.push_back(4'b1000);
    ew(3, 8'h60, 0);
    @(negedge clk);
    chk("t6_arb_cycle", {i_empty, gnt}, 0);
    @(negedge clk);
    chk("t6_gnt", gnt, 4'b1000);
    wait_drain(5, "t6_drain");
    wait_gnt(4'b0000, 20, "t6_stall_release");
    req = '0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
